program_memory: RTL
===================

Name: program_memory

Overview:
Parametrised, synchronous instruction memory for the 8-bit RISC CPU. It replaces the hard-coded combinational ROM with a clocked read port with 1-cycle latency, and adds a byte-serial program-load port. Software can therefore be downloaded at run time from a host or UART bridge without resynthesis. The block sits between the PC register and the decoder, and holds the CPU fetch path in a stalled state while a load is in progress.

Parameters:
ADDR_W, 8, width of pc and of the internal word address
INSTR_W, 16, instruction width in bits; must be a multiple of 8
DEPTH, 256, number of instruction words; must be <= 2**ADDR_W
BYTES_PER_WORD, INSTR_W/8, derived value; not overridable

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
fetch_en  in  1  CPU requests the instruction at pc this cycle
pc  in  ADDR_W  word address to fetch
instr  out  INSTR_W  fetched instruction, registered
instr_valid  out  1  instr holds valid data for the previous cycle's fetch
load_start  in  1  single-cycle pulse: enter LOAD and clear the write pointer
load_byte  in  8  program byte, MSB-first within each word
load_valid  in  1  load_byte is valid this cycle
load_end  in  1  single-cycle pulse: leave LOAD
busy  out  1  high while in LOAD; the CPU must stall
load_count  out  ADDR_W+1  number of complete words written in the current or last load
overflow  out  1  sticky: a word was dropped because the write address reached DEPTH

Behaviour:
- Reset (synchronous, active-high): state=RUN; instr=0, instr_valid=0, busy=0, load_count=0, overflow=0; byte assembler and write pointer cleared.
- Reset does not alter memory contents. Contents are zero at time 0.
- FSM has two states: RUN and LOAD.
- RUN, fetch read:
  - fetch_en=1 at edge N: instr = mem[pc] and instr_valid=1 after edge N. Latency is exactly 1 cycle.
  - fetch_en=0: instr holds its value and instr_valid=0.
  - pc >= DEPTH: instr=0, instr_valid=1, memory unaffected.
- RUN -> LOAD on load_start=1:
  - busy=1 from the next cycle.
  - Write pointer, byte counter and load_count cleared; overflow cleared.
- LOAD, fetch path:
  - fetch_en ignored; instr_valid=0; instr holds its value.
- LOAD, byte assembly:
  - Each load_valid=1 shifts load_byte into the word assembler. The first byte received becomes bits [INSTR_W-1:INSTR_W-8].
  - On the BYTES_PER_WORD-th byte, the complete word is written to mem[wptr] in that same edge; wptr and load_count increment and the byte counter wraps to 0.
  - If wptr == DEPTH when a word completes, the word is dropped, overflow is set, and wptr and load_count stay at DEPTH.
- LOAD -> RUN on load_end=1:
  - busy=0 from the next cycle.
  - A partially assembled word is discarded; load_count excludes it.
  - If load_valid=1 arrives in the same cycle as load_end, that byte is still accepted (and may complete a word) before the exit.
- load_start while already in LOAD restarts the load: pointer, count and overflow cleared, and the partial word discarded.
- load_start and load_end asserted together: load_start wins (state is LOAD).
- load_end in RUN and load_valid in RUN are ignored.
- reset asserted mid-LOAD: returns to RUN. Words already written remain in memory; load_count=0.
- Memory is a single array with one registered read port and one write port, suitable for block-RAM inference. Read and write never occur in the same cycle by construction.

Test Plan:
- Reset, then fetch_en=1 with pc=0..3 on successive cycles -> instr=0 and instr_valid=1 one cycle after each request; instr_valid=0 in the reset cycle.
- load_start; bytes C0,05,C1,07,00,10; load_end -> load_count=3, busy low after load_end. Fetch pc=0,1,2 -> C005, C107, 0010, each 1 cycle after the request.
- During LOAD, fetch_en=1 with pc=0 -> instr_valid=0 and instr unchanged. After load_end, fetch pc=1 -> C107.
- Load 5 bytes (2 full words plus 1 byte), then load_end -> load_count=2; mem[2] is unchanged from its prior value.
- DEPTH=4 instance: load 10 bytes (5 words) -> mem[0..3] written, overflow=1, load_count=4. A new load_start clears overflow.
- Assert reset for 1 cycle after 3 bytes of a load -> busy=0 and load_count=0. mem[0] holds the first word; mem[1] is unchanged.

Source files
------------

// File: rtl/program_memory.sv
// program_memory: synchronous instruction memory for the 8-bit RISC CPU.
// A registered read port (1-cycle latency) feeds the decoder. A byte-serial
// load port writes words into the same array at run time. The fetch path
// stalls while a load is in progress.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   fetch_en     fetch request for the word at pc
//   pc           word address to fetch
//   instr        registered instruction (0 after reset or out-of-range fetch)
//   instr_valid  instr answers the previous cycle's fetch
//   load_start   pulse: enter LOAD (or restart it), clear pointer and overflow
//   load_byte    program byte, MSB-first within each word
//   load_valid   load_byte is valid this cycle
//   load_end     pulse: leave LOAD, discarding any partial word
//   busy         high while in LOAD
//   load_count   complete words written by the current or last load
//   overflow     sticky: a completed word found no room and was dropped
module program_memory #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               load_start,
    input  logic [7:0]         load_byte,
    input  logic               load_valid,
    input  logic               load_end,
    output logic               busy,
    output logic [ADDR_W:0]    load_count,
    output logic               overflow
);

    localparam int BYTES_PER_WORD = INSTR_W / 8;
    localparam int BC_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Assembler keeps only the bytes that precede the final one of a word.
    localparam int ASM_W = (INSTR_W > 8) ? INSTR_W - 8 : 1;

    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_LOAD = 1'b1;

    logic [INSTR_W-1:0] mem [DEPTH] = '{default: '0};

    logic               state_q, state_d;
    logic [ADDR_W:0]    wptr_q, wptr_d;
    logic [BC_W-1:0]    bcnt_q, bcnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic               overflow_q, overflow_d;
    logic               instr_valid_q;
    logic               zero_q;
    logic [INSTR_W-1:0] rdata_q;
    logic [INSTR_W-1:0] next_word;
    logic               we;
    logic               re;
    logic               fetching;
    logic               in_range;

    if (INSTR_W > 8) begin : g_wide
        assign next_word = {asm_q, load_byte};
    end else begin : g_byte
        assign next_word = load_byte;
    end

    assign fetching = (state_q == ST_RUN) && fetch_en;
    assign in_range = ({1'b0, pc} < DEPTH_L);
    assign re       = fetching && in_range && !reset;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        if (load_start) begin
            // Also covers restart and start+end together: start wins.
            state_d    = ST_LOAD;
            wptr_d     = '0;
            bcnt_d     = '0;
            asm_d      = '0;
            overflow_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (load_valid) begin
                asm_d = next_word[ASM_W-1:0];
                if (bcnt_q == LAST_BYTE) begin
                    bcnt_d = '0;
                    if (wptr_q == DEPTH_L) begin
                        overflow_d = 1'b1;
                    end else begin
                        we     = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            // A byte arriving with load_end is taken above before leaving.
            if (load_end) begin
                state_d = ST_RUN;
                bcnt_d  = '0;
            end
        end
    end

    // Array with one write and one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[wptr_q[IDX_W-1:0]] <= next_word;
        end
        if (re) begin
            rdata_q <= mem[pc[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wptr_q        <= '0;
            bcnt_q        <= '0;
            asm_q         <= '0;
            overflow_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            zero_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            bcnt_q        <= bcnt_d;
            asm_q         <= asm_d;
            overflow_q    <= overflow_d;
            instr_valid_q <= fetching;
            // Out-of-range fetches return zero without touching the array.
            if (fetching) begin
                zero_q <= !in_range;
            end
        end
    end

    assign instr       = zero_q ? '0 : rdata_q;
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q == ST_LOAD);
    assign load_count  = wptr_q;
    assign overflow    = overflow_q;

endmodule
